// File: rtl/udp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_parser
// Description : UDP receive parser. Captures the 8-byte UDP header, matches the
//               destination port against a filter table and forwards payload.
//               Optional checksum verification is enabled by UDP_RX_CSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_parser #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic                    ip_header_done,
  input  logic                    ip_header_valid,
  input  logic [16*NUM_PORTS-1:0] port_d_tbl,
  input  logic [NUM_PORTS-1:0]    port_en,
  input  logic [15:0]             pseudo_sum,
  output logic [15:0]             port_s,
  output logic [15:0]             udp_len,
  output logic [IDX_W-1:0]        port_idx,
  output logic                    hdr_done,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    err_port,
  output logic                    err_len,
  output logic                    csum_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  localparam logic [15:0] C_HDR_LEN  = 16'd8;
  localparam logic [15:0] C_LAST_OFF = 16'd9;

  state_t      r_state;
  logic [2:0]  r_hdr_cnt;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_len;
  logic [15:0] r_pay_cnt;

  logic [NUM_PORTS-1:0] w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_any_hit;
  logic                 w_accept;
  logic                 w_hdr_last;
  logic                 w_hdr_ok;
  logic                 w_fin_hdr;
  logic                 w_pay_end;
  logic                 w_fin_pay;
  logic                 w_sum_byte;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_match
      assign w_hit[gi] = port_en[gi] && (port_d_tbl[16*gi +: 16] == r_dst);
    end
  endgenerate

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_any_hit  = |w_hit;
  assign w_accept   = s_valid && (r_state == S_IDLE) && ip_header_done && ip_header_valid;
  assign w_hdr_last = (r_state == S_HDR) && (r_hdr_cnt == 3'd7);
  assign w_hdr_ok   = s_valid && w_hdr_last && (r_len >= C_HDR_LEN) && w_any_hit;
  assign w_fin_hdr  = w_hdr_ok && (r_len == C_HDR_LEN);
  assign w_pay_end  = (r_pay_cnt == (udp_len - C_LAST_OFF));
  assign w_fin_pay  = s_valid && (r_state == S_PAYLOAD) && w_pay_end;
  assign w_sum_byte = s_valid && ((r_state == S_HDR) || (r_state == S_PAYLOAD));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_hdr_cnt <= 3'd0;
      r_src     <= 16'd0;
      r_dst     <= 16'd0;
      r_len     <= 16'd0;
      r_pay_cnt <= 16'd0;
      port_s    <= 16'd0;
      udp_len   <= 16'd0;
      port_idx  <= '0;
      hdr_done  <= 1'b0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      err_port  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      hdr_done <= 1'b0;
      err_port <= 1'b0;
      err_len  <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      if (s_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_src[15:8] <= s_data;
              r_hdr_cnt   <= 3'd1;
              if (s_last) begin
                err_len <= 1'b1;
              end else begin
                r_state <= S_HDR;
              end
            end else if (ip_header_done && !s_last) begin
              r_state <= S_DROP;
            end
          end
          S_HDR: begin
            r_hdr_cnt <= r_hdr_cnt + 3'd1;
            case (r_hdr_cnt)
              3'd1:    r_src[7:0]  <= s_data;
              3'd2:    r_dst[15:8] <= s_data;
              3'd3:    r_dst[7:0]  <= s_data;
              3'd4:    r_len[15:8] <= s_data;
              3'd5:    r_len[7:0]  <= s_data;
              default: ;
            endcase
            if (r_hdr_cnt == 3'd7) begin
              if (r_len < C_HDR_LEN) begin
                err_len <= 1'b1;
                r_state <= s_last ? S_IDLE : S_DROP;
              end else if (!w_any_hit) begin
                err_port <= 1'b1;
                r_state  <= s_last ? S_IDLE : S_DROP;
              end else begin
                hdr_done  <= 1'b1;
                port_s    <= r_src;
                udp_len   <= r_len;
                port_idx  <= w_hit_idx;
                r_pay_cnt <= 16'd0;
                if (r_len == C_HDR_LEN) begin
                  r_state <= S_IDLE;
                end else if (s_last) begin
                  err_len <= 1'b1;
                  r_state <= S_IDLE;
                end else begin
                  r_state <= S_PAYLOAD;
                end
              end
            end else if (s_last) begin
              err_len <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_PAYLOAD: begin
            m_data    <= s_data;
            m_valid   <= 1'b1;
            r_pay_cnt <= r_pay_cnt + 16'd1;
            if (w_pay_end) begin
              m_last  <= 1'b1;
              r_state <= s_last ? S_IDLE : S_DROP;
            end else if (s_last) begin
              m_last  <= 1'b1;
              err_len <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_DROP: begin
            if (s_last) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UDP_RX_CSUM_EN
  function automatic logic [15:0] f_oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  logic [15:0] r_sum;
  logic [15:0] r_fld;
  logic [7:0]  r_hi;
  logic        r_odd;
  logic        r_chk_pend;
  logic        r_chk_bad;
  logic        r_csum_err;
  logic [15:0] w_pair;
  logic [15:0] w_final;
  logic [15:0] w_fld;

  // An unpaired trailing byte is padded with 0x00 in the low half.
  assign w_pair  = r_odd ? {r_hi, s_data} : {s_data, 8'h00};
  assign w_final = f_oc_add(r_sum, w_pair);
  assign w_fld   = (r_state == S_HDR) ? {r_fld[15:8], s_data} : r_fld;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sum      <= 16'd0;
      r_fld      <= 16'd0;
      r_hi       <= 8'd0;
      r_odd      <= 1'b0;
      r_chk_pend <= 1'b0;
      r_chk_bad  <= 1'b0;
      r_csum_err <= 1'b0;
    end else begin
      r_chk_pend <= 1'b0;
      r_csum_err <= r_chk_pend && r_chk_bad;
      if (w_accept) begin
        r_sum <= pseudo_sum;
        r_hi  <= s_data;
        r_odd <= 1'b1;
      end else if (w_sum_byte) begin
        if (r_odd) begin
          r_sum <= w_final;
          r_odd <= 1'b0;
        end else begin
          r_hi  <= s_data;
          r_odd <= 1'b1;
        end
        if ((r_state == S_HDR) && (r_hdr_cnt == 3'd6)) begin
          r_fld[15:8] <= s_data;
        end
        if (w_hdr_last) begin
          r_fld[7:0] <= s_data;
        end
        if (w_fin_hdr || w_fin_pay) begin
          r_chk_pend <= 1'b1;
          r_chk_bad  <= (w_final != 16'hFFFF) && (w_fld != 16'h0000);
        end
      end
    end
  end

  assign csum_err = r_csum_err;
`else
  logic w_unused_csum;
  assign w_unused_csum = ^{pseudo_sum, w_fin_hdr, w_fin_pay, w_sum_byte};
  assign csum_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/udp_rx_parser.md
# udp_rx_parser

Parametrised UDP receive parser. It sits between the IPv4 header receiver and the application payload sinks. It consumes the byte stream that follows a validated IPv4 header and captures the 8-byte UDP header. It matches the destination port against a table of NUM_PORTS entries, then forwards the payload as a qualified byte stream tagged with the matching channel index, flagging length, port and, optionally, checksum errors.

## Interface
- NUM_PORTS, 4: number of destination-port filter entries (1..16).
- IDX_W, $clog2(NUM_PORTS) min 1: width of the channel index.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- s_data  in  8  input byte.
- s_valid  in  1  byte qualifier; low = stall, state held.
- s_last  in  1  last byte of the frame (qualified by s_valid).
- ip_header_done  in  1  high with s_valid on the first UDP byte.
- ip_header_valid  in  1  IPv4 header accepted, sampled with ip_header_done.
- port_d_tbl  in  16*NUM_PORTS  destination ports; entry i at [16*i+15:16*i].
- port_en  in  NUM_PORTS  per-entry enable.
- pseudo_sum  in  16  ones-complement pseudo-header sum (used only with UDP_RX_CSUM_EN).
- port_s  out  16  captured source port.
- udp_len  out  16  captured UDP length field.
- port_idx  out  IDX_W  matched entry index.
- hdr_done  out  1  one-cycle pulse: header accepted.
- m_data  out  8  payload byte.
- m_valid  out  1  payload byte qualifier.
- m_last  out  1  last payload byte.
- err_port  out  1  one-cycle pulse: no enabled entry matched.
- err_len  out  1  one-cycle pulse: length field < 8, or frame truncated.
- csum_err  out  1  one-cycle pulse: checksum mismatch (macro only, else tied 0).

## Operation
- States: IDLE, HDR, PAYLOAD, DROP.
- IDLE:
  - When s_valid & ip_header_done & ip_header_valid, capture byte 0 as port_s[15:8], set hdr count = 1 and go to HDR.
  - When s_valid & ip_header_done & !ip_header_valid, go to DROP.
- HDR: bytes 1..7 captured big-endian, in order: port_s low byte, destination port (internal), udp_len, checksum field (internal). On byte 7:
  - udp_len < 8: err_len pulse, go to DROP (or IDLE if s_last).
  - No enabled entry equals the destination port: err_port pulse, go to DROP/IDLE as above.
  - Otherwise: port_idx = lowest matching index, hdr_done pulse. Go to PAYLOAD if udp_len > 8, else IDLE (no m_valid).
- PAYLOAD:
  - Each s_valid byte is forwarded and the payload counter increments.
  - The byte at count udp_len-9 sets m_last, then go to DROP. Bytes after it (Ethernet padding) are discarded; go to IDLE if that byte carries s_last.
- DROP: discard bytes until s_valid & s_last, then go to IDLE.
- Truncation: s_last before the header or payload completes raises an err_len pulse and returns to IDLE. A truncated payload byte is still forwarded with m_last = 1.
- ip_header_done outside IDLE is ignored.
- Payload counter is 16 bits; udp_len = 0xFFFF supported without wrap.

## Timing
- Reset values: every output is 0, and state = IDLE.
- Reset mid-frame: state = IDLE at once, with no pulses. The next ip_header_done restarts cleanly.
- m_data/m_valid/m_last are registered: latency is 1 cycle from the s_valid byte, with no bubbles beyond input stalls.
- hdr_done, err_port, err_len are asserted the cycle after header byte 7 (or after the truncating byte).
- port_s, udp_len and port_idx are stable from hdr_done until the next accepted header.
- csum_err is asserted the cycle after m_last (or after hdr_done for a zero-length payload).
- Stall: s_valid low freezes state and counters. m_valid is low in the following cycle.

## Configuration
- UDP_RX_CSUM_EN defined:
  - Forms a 16-bit ones-complement sum with end-around carry over pseudo_sum, all header bytes and all payload bytes. Bytes are paired big-endian; an odd final byte is padded with 0x00.
  - csum_err is pulsed when the final sum is not 0xFFFF and the received checksum field is not 0x0000. A zero field means the check is disabled and never errors.
  - Not checked on truncated frames.
- UDP_RX_CSUM_EN undefined: no adder logic, csum_err tied 0, pseudo_sum unused.

## Test plan
- Table {5000, 6000, 7000, 8000}, all enabled; header dst = 7000, len = 12, payload DE AD BE EF -> hdr_done, port_idx = 2, four m_valid bytes with m_last on 0xEF, no errors.
- Same frame with dst = 1234 -> err_port pulse, no m_valid, returns to IDLE after s_last.
- len = 5 -> err_len pulse, no hdr_done. len = 8 -> hdr_done only, zero m_valid.
- len = 12 with s_last on the 2nd payload byte -> two bytes forwarded, m_last on byte 2, err_len pulse. A 6-byte pad after a complete payload is discarded.
- Random s_valid gaps across the first case -> identical output byte sequence. aresetn low mid-payload -> all outputs 0, the next frame parses correctly.
- UDP_RX_CSUM_EN: correct checksum -> no csum_err; one payload bit flipped -> csum_err pulse; checksum field 0x0000 -> no csum_err.
